// File: rtl/vec_gather.sv
// Double-buffered element-to-vector gatherer feeding the linear layer's in_vec.
// Elements collect into a staging buffer, then move to a held output register.
module vec_gather #(
  parameter int DIM   = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIM*WIDTH-1:0]   out_vec,
  output logic                   err_len
);

  localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM - 1);

  logic [WIDTH-1:0]     col_buf_q [DIM];
  logic [WIDTH-1:0]     col_buf_d [DIM];
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 col_full_q, col_full_d;
  logic [DIM*WIDTH-1:0] out_vec_q, out_vec_d;
  logic                 out_valid_q, out_valid_d;
  logic                 err_len_q, err_len_d;

  logic                 accept;
  logic                 take;
  logic                 out_free;
  logic [DIM*WIDTH-1:0] col_vec;
  logic [DIM*WIDTH-1:0] done_vec;

  assign in_ready  = !col_full_q && !rst;
  assign accept    = in_valid && in_ready;
  assign take      = out_valid_q && out_ready;
  assign out_free  = !out_valid_q || take;

  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;
  assign err_len   = err_len_q;

  // done_vec is the staged vector with the completing element patched into the top slot,
  // so a completing accept can load the output register in the same cycle.
  always_comb begin
    col_vec = '0;
    for (int k = 0; k < DIM; k++) begin
      col_vec[k*WIDTH +: WIDTH] = col_buf_q[k];
    end
    done_vec = col_vec;
    done_vec[(DIM-1)*WIDTH +: WIDTH] = in_data;
  end

  always_comb begin
    col_buf_d   = col_buf_q;
    idx_d       = idx_q;
    col_full_d  = col_full_q;
    out_vec_d   = out_vec_q;
    out_valid_d = out_valid_q;
    err_len_d   = 1'b0;

    if (col_full_q) begin
      // accepts are blocked here, so only the pending hand-over can happen
      if (out_free) begin
        out_vec_d   = col_vec;
        out_valid_d = 1'b1;
        col_full_d  = 1'b0;
      end
    end else begin
      if (take) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        if (idx_q == IDX_LAST) begin
          col_buf_d[idx_q] = in_data;
          idx_d            = '0;
          err_len_d        = !in_last;
          if (out_free) begin
            out_vec_d   = done_vec;
            out_valid_d = 1'b1;
          end else begin
            col_full_d  = 1'b1;
          end
        end else if (in_last) begin
          idx_d     = '0;
          err_len_d = 1'b1;
        end else begin
          col_buf_d[idx_q] = in_data;
          idx_d            = idx_q + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DIM; k++) begin
        col_buf_q[k] <= '0;
      end
      idx_q       <= '0;
      col_full_q  <= 1'b0;
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      col_buf_q   <= col_buf_d;
      idx_q       <= idx_d;
      col_full_q  <= col_full_d;
      out_vec_q   <= out_vec_d;
      out_valid_q <= out_valid_d;
      err_len_q   <= err_len_d;
    end
  end

endmodule

// File: tb/tb_vec_gather.sv
// Scoreboard bench for vec_gather: a queue-based reference model predicts vectors,
// framing errors and occupancy; a separate monitor checks every take and err_len.
module tb_vec_gather;
  localparam int DIM = 4;
  localparam int W   = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic           in_last = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [DIM*W-1:0] out_vec;
  logic           err_len;

  vec_gather #(.DIM(DIM), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .err_len(err_len)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DIM*W-1:0] exp_q [$];   // complete vectors held by the DUT, oldest first
  logic [W-1:0]     part_q [$];  // elements of the vector being gathered
  logic             err_now = 1'b0;
  logic             err_exp = 1'b0;
  logic [DIM*W-1:0] held = '0;
  logic             held_v = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; the model follows the spec rules on each accept.
  task automatic cyc(input logic r, input logic v, input logic [W-1:0] d,
                     input logic l, input logic ordy, output logic acc);
    logic [DIM*W-1:0] vec;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r ? 1'b0 : ordy;
    acc       = 1'b0;
    if (r) begin
      exp_q.delete();
      part_q.delete();
    end
    #1;
    err_now = 1'b0;
    if (r) begin
      chk("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
    end else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
      if (v && in_ready) begin
        acc = 1'b1;
        if (part_q.size() == DIM - 1) begin
          part_q.push_back(d);
          vec = '0;
          for (int k = 0; k < DIM; k++) vec[k*W +: W] = part_q[k];
          exp_q.push_back(vec);
          part_q.delete();
          err_now = !l;
        end else if (l) begin
          part_q.delete();
          err_now = 1'b1;
        end else begin
          part_q.push_back(d);
        end
      end
    end
  endtask

  task automatic send_vec(input logic [63:0] v, input logic [3:0] lasts, input int n,
                          input logic ordy);
    logic acc;
    for (int e = 0; e < n; e++) begin
      int tries = 0;
      acc = 1'b0;
      while (!acc && tries < 50) begin
        cyc(1'b0, 1'b1, v[e*W +: W], lasts[e], ordy, acc);
        tries++;
      end
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL send_timeout: element %0d got no accept, expected accept", e);
      end
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, ordy, acc);
  endtask

  // Monitor: pops the scoreboard on every take, checks err_len and output stability.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("err_len", {63'd0, err_len}, {63'd0, err_exp});
      err_exp = err_now;
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (held_v) chk("out_vec_hold", out_vec, held);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL take_unexpected: got vector %h expected none", out_vec);
          end else begin
            chk("out_vec", out_vec, exp_q.pop_front());
          end
          held_v = 1'b0;
        end else begin
          held_v = out_valid;
          held   = out_vec;
        end
      end
    end
  end

  initial begin
    logic acc;
    int   guard;

    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, acc);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, acc);
    idle(1, 1'b1);
    chk("out_vec_reset", out_vec, 64'd0);

    // basic vector
    send_vec(64'h0080_FF00_0200_0100, 4'b1000, 4, 1'b1);
    idle(1, 1'b1);
    chk("basic_valid", {63'd0, out_valid}, 64'd1);
    chk("basic_vec", out_vec, 64'h0080_FF00_0200_0100);
    idle(2, 1'b1);

    // back-pressure: two vectors fill the block, third is refused
    send_vec(64'h1004_1003_1002_1001, 4'b1000, 4, 1'b0);
    send_vec(64'h2004_2003_2002_2001, 4'b1000, 4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 16'h3001, 1'b0, 1'b0, acc);
      chk("bp_refused", {63'd0, acc}, 64'd0);
    end
    send_vec(64'h3004_3003_3002_3001, 4'b1000, 4, 1'b1);
    idle(4, 1'b1);

    // early last then a correct vector
    send_vec(64'h0000_0000_0022_0011, 4'b0010, 2, 1'b1);
    send_vec(64'h0004_0003_0002_0001, 4'b1000, 4, 1'b1);
    idle(3, 1'b1);

    // missing last
    send_vec(64'hDDDD_CCCC_BBBB_AAAA, 4'b0000, 4, 1'b1);
    idle(3, 1'b1);

    // zero-bubble streaming of 5 vectors
    for (int n = 0; n < 5; n++) send_vec({4{16'(n * 16'h0111)}} ^ 64'h0003_0002_0001_0000, 4'b1000, 4, 1'b1);
    idle(3, 1'b1);

    // reset while a vector is pending on the output and two elements are staged
    send_vec(64'h5004_5003_5002_5001, 4'b1000, 4, 1'b0);
    send_vec(64'h0000_0000_6002_6001, 4'b0000, 2, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, acc);
    idle(1, 1'b0);
    send_vec(64'h7004_7003_7002_7001, 4'b1000, 4, 1'b1);
    idle(1, 1'b1);
    chk("post_reset_vec", out_vec, 64'h7004_7003_7002_7001);
    idle(2, 1'b1);

    // randomized traffic with occasional framing errors and resets
    for (int i = 0; i < 1500; i++) begin
      logic r, v, l, o;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) != 0);
      if (part_q.size() == DIM - 1) l = ($urandom_range(0, 9) != 0);
      else                          l = ($urandom_range(0, 14) == 0);
      cyc(r, v, W'($urandom), l, o, acc);
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      idle(1, 1'b1);
      guard++;
    end
    idle(2, 1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
